// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed count of products into a wide accumulator
// Three-state control (IDLE/ACCUM/HOLD) around a single carry-detecting adder.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W:0]    prod_ext;
  logic [ACC_W:0]    sum_ext;
  logic              xfer;

  // One extra bit on the adder captures the carry out of the accumulator.
  always_comb begin
    prod_ext                = '0;
    prod_ext[PROD_W-1:0]    = in_product;
  end

  assign sum_ext = {1'b0, acc_q} + prod_ext;
  assign xfer    = (state_q == S_ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_d = sum_ext[ACC_W-1:0];
          rem_d = rem_q - CNT_W'(1);
          if (sum_ext[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_ACCUM);
    out_valid    = (state_q == S_HOLD);
    busy         = (state_q != S_IDLE);
    out_sum      = acc_q;
    out_overflow = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator at ACC_W=72 and ACC_W=64
// Both instances share stimulus; each has its own expected-result queue.
module tb_product_accumulator;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [63:0] in_product = 64'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_overflow, busy;
  logic [71:0] out_sum;
  logic        in_ready64, out_valid64, out_overflow64, busy64;
  logic [63:0] out_sum64;

  typedef struct {
    logic [71:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q72[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .busy(busy)
  );

  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) u_dut64 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready64), .in_product(in_product),
    .out_valid(out_valid64), .out_ready(out_ready), .out_sum(out_sum64),
    .out_overflow(out_overflow64), .busy(busy64)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [71:0] s72, input logic o72,
                      input logic [71:0] s64, input logic o64);
    exp_t e;
    e.sum = s72; e.ovf = o72; q72.push_back(e);
    e.sum = s64; e.ovf = o64; q64.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p);
    int n = 0;
    in_valid   = 1'b1;
    in_product = p;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Monitor: pops one expected result per output handshake on each instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q72.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb72_unexpected: got sum %0h expected no result", out_sum);
      end else begin
        e = q72.pop_front();
        chk("sb72_sum", out_sum, e.sum);
        chk("sb72_ovf", {71'd0, out_overflow}, {71'd0, e.ovf});
      end
    end
    if (!reset && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb64_unexpected: got sum %0h expected no result", out_sum64);
      end else begin
        e = q64.pop_front();
        chk("sb64_sum", {8'd0, out_sum64}, e.sum);
        chk("sb64_ovf", {71'd0, out_overflow64}, {71'd0, e.ovf});
      end
    end
  end

  initial begin
    logic [5:0] vpat;

    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", {71'd0, in_ready}, 72'd0);
    chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_out_sum", out_sum, 72'd0);
    chk("rst_ovf", {71'd0, out_overflow}, 72'd0);
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst64_busy_ready", {70'd0, busy64, in_ready64}, 72'd0);

    // Job 1: 1+2+3+4 back-to-back
    push(72'd10, 1'b0, 72'd10, 1'b0);
    do_start(8'd4);
    chk("j1_busy", {71'd0, busy}, 72'd1);
    send(64'd1); send(64'd2); send(64'd3);
    chk("j1_not_yet_valid", {71'd0, out_valid}, 72'd0);
    send(64'd4);
    chk("j1_latency_valid", {71'd0, out_valid}, 72'd1);
    chk("j1_hold_in_ready", {71'd0, in_ready}, 72'd0);
    chk("j1_hold_busy", {71'd0, busy}, 72'd1);
    accept();
    chk("j1_idle_valid", {71'd0, out_valid}, 72'd0);

    // Job 2: sparse in_valid, three all-ones products
    push(72'h2_FFFF_FFFF_FFFF_FFFD, 1'b0, 72'h0_FFFF_FFFF_FFFF_FFFD, 1'b1);
    do_start(8'd3);
    vpat = 6'b101001;
    in_product = ONES;
    for (int i = 0; i < 6; i++) begin
      in_valid = vpat[i];
      step();
    end
    in_valid = 1'b0;
    chk("j2_valid_after_3", {71'd0, out_valid}, 72'd1);
    accept();

    // Job 3: wraps at 64 bits only
    push(72'h1_0000_0000_0000_0001, 1'b0, 72'd1, 1'b1);
    do_start(8'd2);
    send(ONES); send(64'd2);
    chk("j3_valid", {71'd0, out_valid64}, 72'd1);
    accept();

    // Job 4: overflow cleared by new job; out_ready high before out_valid
    push(72'd5, 1'b0, 72'd5, 1'b0);
    out_ready = 1'b1;
    do_start(8'd1);
    send(64'd5);
    chk("j4_valid_first_hold", {71'd0, out_valid}, 72'd1);
    step();
    out_ready = 1'b0;
    chk("j4_idle", {70'd0, out_valid, busy}, 72'd0);

    // Job 5: empty job, held result, ignored starts
    push(72'd0, 1'b0, 72'd0, 1'b0);
    do_start(8'd0);
    chk("j5_valid", {71'd0, out_valid}, 72'd1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd3;
      step();
      start = 1'b0;
      chk("j5_hold_valid", {71'd0, out_valid}, 72'd1);
      chk("j5_hold_sum", out_sum, 72'd0);
    end
    start = 1'b1; len = 8'd3;
    accept();
    start = 1'b0;
    chk("j5_start_on_accept_ignored", {70'd0, busy, in_ready}, 72'd0);

    // Job 6: reset mid-job discards the partial sum
    do_start(8'd4);
    send(64'd3); send(64'd4);
    chk("j6_partial", out_sum, 72'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("j6_rst_sum", out_sum, 72'd0);
    chk("j6_rst_ctrl", {69'd0, busy, in_ready, out_valid}, 72'd0);
    push(72'd9, 1'b0, 72'd9, 1'b0);
    do_start(8'd1);
    send(64'd9);
    accept();

    // Job 7: start during ACCUM ignored; back-pressure
    push(72'd11, 1'b0, 72'd11, 1'b0);
    do_start(8'd2);
    send(64'd5);
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    send(64'd6);
    chk("j7_valid_after_2", {71'd0, out_valid}, 72'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("j7_bp_sum", out_sum, 72'd11);
      chk("j7_bp_valid", {71'd0, out_valid}, 72'd1);
    end
    accept();
    step();

    chk("sb72_drained", 72'(q72.size()), 72'd0);
    chk("sb64_drained", 72'(q64.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 32x32 multiplier's 64-bit product stream.
- Accepts a programmed number of products over a valid/ready handshake and sums them into a wide accumulator.
- Presents the sum on a held valid/ready output for dot-product and MAC-style datapaths.
- Purely sequential control around a single adder; contains no multiplier of its own.

Parameters:
- PROD_W, 64, width of each incoming product.
- ACC_W, 72, accumulator and output sum width; must be >= PROD_W.
- CNT_W, 8, width of the length field; one job sums at most 2^CNT_W-1 products.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle job request; sampled only in IDLE
- len  input  CNT_W  number of products in the job; sampled with start
- in_valid  input  1  in_product is valid this cycle
- in_ready  output  1  block accepts a product this cycle
- in_product  input  PROD_W  unsigned product from the multiplier
- out_valid  output  1  out_sum/out_overflow valid and held
- out_ready  input  1  consumer takes the result
- out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W
- out_overflow  output  1  sticky: a carry out of ACC_W occurred during the job
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: reset high at a rising edge forces state to IDLE, clears acc, remaining count and the overflow flag.
- All outputs are 0 after reset: in_ready, out_valid, out_sum, out_overflow, busy.
- Reset overrides everything. An in-flight job is abandoned and its partial sum is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 with len!=0: next cycle acc=0, overflow=0, remaining=len, go to ACCUM.
  - start=1 with len==0: next cycle acc=0, overflow=0, go directly to HOLD (empty job yields sum 0).
- ACCUM:
  - in_ready=1 combinationally (state-decoded only, not dependent on in_valid); busy=1.
  - A transfer occurs when in_valid && in_ready. On a transfer: acc <= acc + zero-extended in_product, remaining <= remaining-1.
  - If the addition carries out of bit ACC_W-1, overflow <= 1. The flag is sticky and acc wraps.
  - A transfer with remaining==1 moves the block to HOLD on the same edge.
  - With no transfer, all state holds.
- HOLD:
  - out_valid=1; out_sum=acc and out_overflow=overflow, held stable until accepted.
  - in_ready=0, busy=1.
  - out_ready=1: next cycle go to IDLE with out_valid=0. out_sum keeps its last value and is don't-care once valid drops.
  - out_ready may be high before out_valid; acceptance happens in the first HOLD cycle.
- Latency: last product accepted at edge t -> out_valid high in the cycle after t. Throughput is one product per cycle in ACCUM.
- start asserted outside IDLE is ignored; no queuing.
- start in the same cycle HOLD is accepted is also ignored, because the block is not yet in IDLE.
- len is sampled only on accepted start; later changes have no effect on the running job.
- in_product is ignored whenever in_ready=0.
- The minimum job-to-job gap is 1 IDLE cycle.

Test Plan:
- Reset, then len=4, products 1, 2, 3, 4 back-to-back with in_valid held -> out_valid exactly 1 cycle after the 4th transfer, out_sum=10, out_overflow=0, in_ready=0 during HOLD.
- len=3, in_valid toggled 1,0,0,1,0,1 with products 0xFFFFFFFF_FFFFFFFF each -> only 3 transfers counted, out_sum=0x2_FFFFFFFF_FFFFFFFD.
- ACC_W=64, len=2, products 0xFFFFFFFF_FFFFFFFF and 2 -> out_sum=1, out_overflow=1. Next job len=1, product 5 -> out_sum=5, out_overflow=0.
- len=0 start -> out_valid 1 cycle later with out_sum=0; hold out_ready=0 for 5 cycles -> out_sum stable, start pulses ignored; then out_ready=1 -> IDLE.
- Reset asserted after 2 of 4 products (sum 7) -> next cycle all outputs 0, state IDLE. New job len=1, product 9 -> out_sum=9.
- start pulsed during ACCUM with a different len -> ignored, original count completes; out_ready low-then-high back-pressure verified with no data change.
